// File: rtl/jtag_tap_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtag_tap_ctrl: 16-state TAP FSM with IR, BYPASS, IDCODE and one user DR  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module jtag_tap_ctrl #(
  parameter int          IR_WIDTH   = 4,
  parameter int          DR_WIDTH   = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter int          OPC_IDCODE = 1,
  parameter int          OPC_USER   = 2
) (
  input  logic                TCLK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  output logic [3:0]          STATE,
  output logic [IR_WIDTH-1:0] IR,
  output logic                USER_SEL,
  input  logic [DR_WIDTH-1:0] USER_DIN,
  output logic [DR_WIDTH-1:0] USER_DOUT,
  output logic                USER_UPD
);

  generate
    if (IDCODE_VAL[0] != 1'b1) begin : g_idcode_lsb_check
      $error("jtag_tap_ctrl: IDCODE_VAL bit 0 must be 1");
    end
    if (IR_WIDTH < 2) begin : g_ir_width_check
      $error("jtag_tap_ctrl: IR_WIDTH must be at least 2");
    end
    if (DR_WIDTH < 1) begin : g_dr_width_check
      $error("jtag_tap_ctrl: DR_WIDTH must be at least 1");
    end
  endgenerate

  typedef enum logic [3:0] {
    TAP_TLR      = 4'd0,
    TAP_IDLE     = 4'd1,
    TAP_SEL_DR   = 4'd2,
    TAP_CAP_DR   = 4'd3,
    TAP_SHI_DR   = 4'd4,
    TAP_EXIT1_DR = 4'd5,
    TAP_PAUSE_DR = 4'd6,
    TAP_EXIT2_DR = 4'd7,
    TAP_UPD_DR   = 4'd8,
    TAP_SEL_IR   = 4'd9,
    TAP_CAP_IR   = 4'd10,
    TAP_SHI_IR   = 4'd11,
    TAP_EXIT1_IR = 4'd12,
    TAP_PAUSE_IR = 4'd13,
    TAP_EXIT2_IR = 4'd14,
    TAP_UPD_IR   = 4'd15
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] c_opc_idcode = IR_WIDTH'(OPC_IDCODE);
  localparam logic [IR_WIDTH-1:0] c_opc_user   = IR_WIDTH'(OPC_USER);
  localparam logic [IR_WIDTH-1:0] c_ir_capture = IR_WIDTH'(1);

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [31:0]         id_sr_q, id_sr_d;
  logic [DR_WIDTH-1:0] user_sr_q, user_sr_d;
  logic                byp_q, byp_d;
  logic [DR_WIDTH-1:0] user_dout_q, user_dout_d;
  logic                user_upd_q, user_upd_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;

  logic                sel_idcode;
  logic                sel_user;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [DR_WIDTH-1:0] user_shift;
  logic                dr_bit0;

  assign sel_idcode = (ir_q == c_opc_idcode);
  assign sel_user   = (ir_q == c_opc_user);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TAP_TLR:      state_d = TMS ? TAP_TLR      : TAP_IDLE;
      TAP_IDLE:     state_d = TMS ? TAP_SEL_DR   : TAP_IDLE;
      TAP_SEL_DR:   state_d = TMS ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   state_d = TMS ? TAP_EXIT1_DR : TAP_SHI_DR;
      TAP_SHI_DR:   state_d = TMS ? TAP_EXIT1_DR : TAP_SHI_DR;
      TAP_EXIT1_DR: state_d = TMS ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: state_d = TMS ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: state_d = TMS ? TAP_UPD_DR   : TAP_SHI_DR;
      TAP_UPD_DR:   state_d = TMS ? TAP_SEL_DR   : TAP_IDLE;
      TAP_SEL_IR:   state_d = TMS ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   state_d = TMS ? TAP_EXIT1_IR : TAP_SHI_IR;
      TAP_SHI_IR:   state_d = TMS ? TAP_EXIT1_IR : TAP_SHI_IR;
      TAP_EXIT1_IR: state_d = TMS ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: state_d = TMS ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: state_d = TMS ? TAP_UPD_IR   : TAP_SHI_IR;
      TAP_UPD_IR:   state_d = TMS ? TAP_SEL_DR   : TAP_IDLE;
    endcase
  end

  // Shift paths written as shift-then-insert so a 1-bit user DR still works.
  always_comb begin
    ir_shift               = ir_sr_q >> 1;
    ir_shift[IR_WIDTH-1]   = TDI;
    user_shift             = user_sr_q >> 1;
    user_shift[DR_WIDTH-1] = TDI;

    ir_d        = ir_q;
    ir_sr_d     = ir_sr_q;
    id_sr_d     = id_sr_q;
    user_sr_d   = user_sr_q;
    byp_d       = byp_q;
    user_dout_d = user_dout_q;
    user_upd_d  = 1'b0;

    case (state_q)
      TAP_TLR:    ir_d    = c_opc_idcode;
      TAP_CAP_IR: ir_sr_d = c_ir_capture;
      TAP_SHI_IR: ir_sr_d = ir_shift;
      TAP_UPD_IR: ir_d    = ir_sr_q;
      TAP_CAP_DR: begin
        id_sr_d   = IDCODE_VAL;
        user_sr_d = USER_DIN;
        byp_d     = 1'b0;
      end
      TAP_SHI_DR: begin
        if (sel_idcode) begin
          id_sr_d = {TDI, id_sr_q[31:1]};
        end else if (sel_user) begin
          user_sr_d = user_shift;
        end else begin
          byp_d = TDI;
        end
      end
      TAP_UPD_DR: begin
        if (sel_user) begin
          user_dout_d = user_sr_q;
          user_upd_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge TCLK or posedge TRST) begin
    if (TRST) begin
      state_q     <= TAP_TLR;
      ir_q        <= c_opc_idcode;
      ir_sr_q     <= '0;
      id_sr_q     <= '0;
      user_sr_q   <= '0;
      byp_q       <= 1'b0;
      user_dout_q <= '0;
      user_upd_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      ir_sr_q     <= ir_sr_d;
      id_sr_q     <= id_sr_d;
      user_sr_q   <= user_sr_d;
      byp_q       <= byp_d;
      user_dout_q <= user_dout_d;
      user_upd_q  <= user_upd_d;
    end
  end

  // TDO is retimed to the falling edge so it is stable around the next rising edge.
  always_comb begin
    dr_bit0  = sel_idcode ? id_sr_q[0] : (sel_user ? user_sr_q[0] : byp_q);
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (state_q == TAP_SHI_DR) begin
      tdo_d    = dr_bit0;
      tdo_en_d = 1'b1;
    end else if (state_q == TAP_SHI_IR) begin
      tdo_d    = ir_sr_q[0];
      tdo_en_d = 1'b1;
    end
  end

  always_ff @(negedge TCLK or posedge TRST) begin
    if (TRST) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign STATE     = state_q;
  assign IR        = ir_q;
  assign USER_SEL  = sel_user;
  assign USER_DOUT = user_dout_q;
  assign USER_UPD  = user_upd_q;
  assign TDO       = tdo_q;
  assign TDO_EN    = tdo_en_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_jtag_tap_ctrl: table walk, directed scans and random TMS/TDI traffic  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_jtag_tap_ctrl;

  localparam logic [31:0] IDV = 32'h1000_0001;

  logic       TCLK = 1'b0;
  logic       TRST, TMS, TDI;
  logic       TDO, TDO_EN;
  logic [3:0] STATE;
  logic [3:0] IR;
  logic       USER_SEL;
  logic [7:0] USER_DIN, USER_DOUT;
  logic       USER_UPD;

  int n_err = 0;
  int n_chk = 0;

  always #5 TCLK = ~TCLK;

  jtag_tap_ctrl #(
    .IR_WIDTH  (4),
    .DR_WIDTH  (8),
    .IDCODE_VAL(IDV),
    .OPC_IDCODE(1),
    .OPC_USER  (2)
  ) dut (
    .TCLK     (TCLK),
    .TRST     (TRST),
    .TMS      (TMS),
    .TDI      (TDI),
    .TDO      (TDO),
    .TDO_EN   (TDO_EN),
    .STATE    (STATE),
    .IR       (IR),
    .USER_SEL (USER_SEL),
    .USER_DIN (USER_DIN),
    .USER_DOUT(USER_DOUT),
    .USER_UPD (USER_UPD)
  );

  // Reference model: TAP graph as a lookup table, registers as plain words.
  int          ns_tab [16][2];
  int          m_state;
  logic [3:0]  m_ir, m_ir_sr;
  logic [31:0] m_id_sr;
  logic [7:0]  m_user_sr, m_dout;
  logic        m_byp, m_upd, m_tdo, m_en;
  logic        last_tdo;
  int          en_count;

  typedef struct packed {
    logic       tms;
    logic       tdi;
    logic [3:0] st;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ir = 4'd1; m_ir_sr = '0; m_id_sr = '0;
    m_user_sr = '0; m_dout = '0; m_byp = 1'b0; m_upd = 1'b0;
    m_tdo = 1'b0; m_en = 1'b0;
  endtask

  function automatic int model_sel();
    if (m_ir == 4'd1) return 1;
    if (m_ir == 4'd2) return 2;
    return 0;
  endfunction

  task automatic model_rise();
    int   sel;
    logic upd;
    sel = model_sel();
    upd = 1'b0;
    case (m_state)
      0:  m_ir = 4'd1;
      3:  begin m_id_sr = IDV; m_user_sr = USER_DIN; m_byp = 1'b0; end
      4:  begin
            if (sel == 1)      m_id_sr   = {TDI, m_id_sr[31:1]};
            else if (sel == 2) m_user_sr = {TDI, m_user_sr[7:1]};
            else               m_byp     = TDI;
          end
      8:  if (sel == 2) begin m_dout = m_user_sr; upd = 1'b1; end
      10: m_ir_sr = 4'b0001;
      11: m_ir_sr = {TDI, m_ir_sr[3:1]};
      15: m_ir = m_ir_sr;
      default: ;
    endcase
    m_upd   = upd;
    m_state = ns_tab[m_state][TMS ? 1 : 0];
  endtask

  task automatic model_fall();
    int sel;
    sel   = model_sel();
    m_en  = (m_state == 4) || (m_state == 11);
    m_tdo = 1'b0;
    if (m_state == 4)       m_tdo = (sel == 1) ? m_id_sr[0] : ((sel == 2) ? m_user_sr[0] : m_byp);
    else if (m_state == 11) m_tdo = m_ir_sr[0];
  endtask

  // One TCLK cycle; entered and left just after a falling edge.
  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCLK);
    model_rise();
    #1;
    chk("state",     32'(STATE),     32'(m_state));
    chk("ir",        32'(IR),        32'(m_ir));
    chk("user_sel",  32'(USER_SEL),  32'(m_ir == 4'd2));
    chk("user_dout", 32'(USER_DOUT), 32'(m_dout));
    chk("user_upd",  32'(USER_UPD),  32'(m_upd));
    @(negedge TCLK);
    model_fall();
    #1;
    chk("tdo",    32'(TDO),    32'(m_tdo));
    chk("tdo_en", 32'(TDO_EN), 32'(m_en));
    last_tdo = TDO;
    if (TDO_EN) en_count++;
  endtask

  // IDLE -> shift IR -> UpdIR -> IDLE
  task automatic scan_ir(input logic [3:0] val, output logic [3:0] out);
    out = '0;
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      out[i] = last_tdo;
      tick(i == 3, val[i]);
    end
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
  endtask

  // IDLE -> shift n DR bits -> UpdDR -> IDLE
  task automatic scan_dr(input int n, input logic [31:0] val, output logic [31:0] out);
    out = '0;
    tick(1'b1, 1'b0);
    en_count = 0;
    tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      out[i] = last_tdo;
      tick(i == n - 1, val[i]);
    end
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
  endtask

  task automatic add_vec(input logic tms, input logic [3:0] st);
    vec_t v;
    v.tms = tms; v.tdi = 1'b0; v.st = st;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  o4;
    logic [31:0] o32;
    logic [7:0]  val8, din8;
    logic        rtms;

    ns_tab = '{'{1,0}, '{1,2}, '{3,9}, '{4,5}, '{4,5}, '{6,8}, '{6,7}, '{4,8},
               '{1,2}, '{10,0}, '{11,12}, '{11,12}, '{13,15}, '{13,14}, '{11,15}, '{1,2}};

    add_vec(0,1);  add_vec(0,1);  add_vec(1,2);  add_vec(0,3);  add_vec(0,4);
    add_vec(1,5);  add_vec(0,6);  add_vec(0,6);  add_vec(1,7);  add_vec(0,4);
    add_vec(1,5);  add_vec(1,8);  add_vec(1,2);  add_vec(1,9);  add_vec(0,10);
    add_vec(0,11); add_vec(0,11); add_vec(1,12); add_vec(0,13); add_vec(1,14);
    add_vec(0,11); add_vec(1,12); add_vec(1,15); add_vec(0,1);  add_vec(1,2);
    add_vec(0,3);  add_vec(1,5);  add_vec(1,8);  add_vec(0,1);  add_vec(1,2);
    add_vec(1,9);  add_vec(0,10); add_vec(1,12); add_vec(1,15); add_vec(1,2);
    add_vec(1,9);  add_vec(1,0);  add_vec(1,0);

    TRST = 1'b1; TMS = 1'b1; TDI = 1'b0; USER_DIN = 8'h00; last_tdo = 1'b0; en_count = 0;
    #12;
    chk("rst_state",  32'(STATE),     32'd0);
    chk("rst_ir",     32'(IR),        32'd1);
    chk("rst_tdo",    32'(TDO),       32'd0);
    chk("rst_tdo_en", 32'(TDO_EN),    32'd0);
    chk("rst_dout",   32'(USER_DOUT), 32'd0);
    chk("rst_upd",    32'(USER_UPD),  32'd0);
    TRST = 1'b0;
    model_reset();

    tick(1'b0, 1'b0);
    scan_dr(32, $urandom, o32);
    chk("idcode_out", o32, IDV);
    chk("idcode_en_edges", 32'(en_count), 32'd32);

    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    chk("in_shidr", 32'(STATE), 32'd4);
    repeat (5) tick(1'b1, 1'($urandom));
    chk("tms5_tlr", 32'(STATE), 32'd0);
    tick(1'b0, 1'b0);

    scan_ir(4'b0010, o4);
    chk("ir_capture_out", 32'(o4), 32'h1);
    chk("ir_user", 32'(IR), 32'd2);
    chk("user_sel_hi", 32'(USER_SEL), 32'd1);

    USER_DIN = 8'hA5;
    scan_dr(8, 32'h3C, o32);
    chk("user_capture_out", 32'(o32[7:0]), 32'hA5);
    chk("user_dout", 32'(USER_DOUT), 32'h3C);
    chk("user_upd_pulse", 32'(USER_UPD), 32'd1);
    tick(1'b0, 1'b0);
    chk("user_upd_drop", 32'(USER_UPD), 32'd0);

    scan_ir(4'hF, o4);
    scan_dr(8, 32'hC3, o32);
    chk("bypass_f_out", 32'(o32[7:0]), 32'h86);
    chk("bypass_f_dout_held", 32'(USER_DOUT), 32'h3C);
    scan_ir(4'h7, o4);
    scan_dr(8, 32'hC3, o32);
    chk("bypass_7_out", 32'(o32[7:0]), 32'h86);
    chk("bypass_7_upd", 32'(USER_UPD), 32'd0);

    scan_ir(4'h2, o4);
    din8 = 8'($urandom); val8 = 8'($urandom);
    USER_DIN = din8;
    o32 = '0;
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin o32[i] = last_tdo; tick(i == 3, val8[i]); end
    tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    chk("in_pause", 32'(STATE), 32'd6);
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    for (int i = 4; i < 8; i++) begin o32[i] = last_tdo; tick(i == 7, val8[i]); end
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    chk("pause_scan_out", 32'(o32[7:0]), 32'(din8));
    chk("pause_scan_dout", 32'(USER_DOUT), 32'(val8));

    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b1);
    TRST = 1'b1;
    #1;
    chk("midscan_rst_state", 32'(STATE), 32'd0);
    chk("midscan_rst_dout",  32'(USER_DOUT), 32'd0);
    chk("midscan_rst_ir",    32'(IR), 32'd1);
    chk("midscan_rst_en",    32'(TDO_EN), 32'd0);
    #1;
    TRST = 1'b0;
    model_reset();

    foreach (vecs[k]) begin
      tick(vecs[k].tms, vecs[k].tdi);
      chk($sformatf("walk%0d", k), 32'(STATE), 32'(vecs[k].st));
    end

    repeat (500) begin
      if ($urandom_range(0, 7) == 0) USER_DIN = 8'($urandom);
      rtms = ($urandom_range(0, 99) < 35);
      tick(rtms, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
